// File: rtl/id_stage.sv
// id_stage: decode stage of the 5-stage pipeline. It holds the IF/ID register, the register
// file, the decoder, hazard detection, and branch/jump resolution that redirects fetch.
module id_stage #(
  parameter logic [31:0] NOP_INST  = 32'h0000_0000,
  parameter bit          RF_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc4,
  input  logic [31:0] if_inst,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rn,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_rn,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_rn,
  input  logic [31:0] wb_data,
  output logic [31:0] npc,
  output logic [31:0] nid_pc,
  output logic        ctrl_branch,
  output logic        jmp_stall,
  output logic        id_wpcir,
  output logic [31:0] id_ra,
  output logic [31:0] id_rb,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rn,
  output logic        id_wreg,
  output logic        id_m2reg,
  output logic        id_wmem,
  output logic        id_aluimm,
  output logic        id_shift,
  output logic [3:0]  id_aluc
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  logic [31:0] r_pc4;
  logic [31:0] r_inst;
  logic [31:0] r_regs [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [31:0] w_sext, w_zext;
  logic [31:0] w_ra, w_rb, w_imm, w_target;
  logic [4:0]  w_rn;
  logic [3:0]  w_aluc;
  logic        w_wreg, w_m2reg, w_wmem, w_aluimm, w_shift;
  logic        w_beq, w_bne, w_j, w_uses_rt;
  logic        w_load_use, w_br_haz, w_taken;

  assign w_op    = r_inst[31:26];
  assign w_rs    = r_inst[25:21];
  assign w_rt    = r_inst[20:16];
  assign w_rd    = r_inst[15:11];
  assign w_shamt = r_inst[10:6];
  assign w_funct = r_inst[5:0];
  assign w_sext  = {{16{r_inst[15]}}, r_inst[15:0]};
  assign w_zext  = {16'b0, r_inst[15:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc4  <= '0;
      r_inst <= NOP_INST;
    end else if (!id_wpcir) begin
      if (ctrl_branch) begin
        r_pc4  <= '0;
        r_inst <= NOP_INST;
      end else begin
        r_pc4  <= if_pc4;
        r_inst <= if_inst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (wb_wreg && wb_rn != 5'd0) begin
      r_regs[wb_rn] <= wb_data;
    end
  end

  always_comb begin
    w_ra = '0;
    w_rb = '0;
    if (w_rs != 5'd0)
      w_ra = (RF_BYPASS && wb_wreg && wb_rn == w_rs) ? wb_data : r_regs[w_rs];
    if (w_rt != 5'd0)
      w_rb = (RF_BYPASS && wb_wreg && wb_rn == w_rt) ? wb_data : r_regs[w_rt];
  end

  // The canonical NOP decodes to a pure bubble so reset/flush slots drive no controls.
  always_comb begin
    w_wreg    = 1'b0;
    w_m2reg   = 1'b0;
    w_wmem    = 1'b0;
    w_aluimm  = 1'b0;
    w_shift   = 1'b0;
    w_aluc    = ALU_ADD;
    w_imm     = w_sext;
    w_rn      = w_rt;
    w_beq     = 1'b0;
    w_bne     = 1'b0;
    w_j       = 1'b0;
    w_uses_rt = 1'b0;
    if (r_inst == NOP_INST) begin
      w_imm = '0;
      w_rn  = '0;
    end else begin
      case (w_op)
        OP_R: begin
          w_rn      = w_rd;
          w_uses_rt = 1'b1;
          case (w_funct)
            F_ADD: begin w_wreg = 1'b1; w_aluc = ALU_ADD; end
            F_SUB: begin w_wreg = 1'b1; w_aluc = ALU_SUB; end
            F_AND: begin w_wreg = 1'b1; w_aluc = ALU_AND; end
            F_OR:  begin w_wreg = 1'b1; w_aluc = ALU_OR;  end
            F_NOR: begin w_wreg = 1'b1; w_aluc = ALU_NOR; end
            F_SLT: begin w_wreg = 1'b1; w_aluc = ALU_SLT; end
            F_SLL: begin w_wreg = 1'b1; w_aluc = ALU_SLL; w_shift = 1'b1; w_imm = {27'b0, w_shamt}; end
            F_SRL: begin w_wreg = 1'b1; w_aluc = ALU_SRL; w_shift = 1'b1; w_imm = {27'b0, w_shamt}; end
            F_SRA: begin w_wreg = 1'b1; w_aluc = ALU_SRA; w_shift = 1'b1; w_imm = {27'b0, w_shamt}; end
            default: ;
          endcase
        end
        OP_ADDI: begin w_wreg = 1'b1; w_aluimm = 1'b1; end
        OP_ANDI: begin w_wreg = 1'b1; w_aluimm = 1'b1; w_aluc = ALU_AND; w_imm = w_zext; end
        OP_ORI:  begin w_wreg = 1'b1; w_aluimm = 1'b1; w_aluc = ALU_OR;  w_imm = w_zext; end
        OP_LW:   begin w_wreg = 1'b1; w_m2reg = 1'b1; w_aluimm = 1'b1; end
        OP_SW:   begin w_wmem = 1'b1; w_aluimm = 1'b1; w_uses_rt = 1'b1; end
        OP_BEQ:  begin w_beq = 1'b1; w_uses_rt = 1'b1; end
        OP_BNE:  begin w_bne = 1'b1; w_uses_rt = 1'b1; end
        OP_J:    w_j = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_load_use = ex_wreg & ex_m2reg & (ex_rn != 5'd0) &
                      ((ex_rn == w_rs) | (w_uses_rt & (ex_rn == w_rt)));
  // Branches compare in ID, so any in-flight producer of rs/rt must retire first.
  assign w_br_haz   = (w_beq | w_bne) &
                      ((ex_wreg & (ex_rn != 5'd0) & ((ex_rn == w_rs) | (ex_rn == w_rt))) |
                       (mem_wreg & (mem_rn != 5'd0) & ((mem_rn == w_rs) | (mem_rn == w_rt))));

  assign id_wpcir = w_load_use | w_br_haz;
  assign w_taken  = ~id_wpcir & ((w_beq & (w_ra == w_rb)) | (w_bne & (w_ra != w_rb)) | w_j);
  assign w_target = w_j ? {r_pc4[31:26], r_inst[25:0]} : r_pc4 + w_sext;

  assign ctrl_branch = w_taken;
  assign jmp_stall   = w_taken;
  assign nid_pc      = w_taken ? w_target : '0;
  assign npc         = w_taken ? w_target : if_pc4;

  assign id_ra     = w_ra;
  assign id_rb     = w_rb;
  assign id_imm    = w_imm;
  assign id_rn     = w_rn;
  assign id_wreg   = w_wreg  & ~id_wpcir;
  assign id_m2reg  = w_m2reg & ~id_wpcir;
  assign id_wmem   = w_wmem  & ~id_wpcir;
  assign id_aluimm = w_aluimm;
  assign id_shift  = w_shift;
  assign id_aluc   = w_aluc;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and random checks of id_stage against a mnemonic-level
// model of the decode stage (register file, IF/ID, hazards, redirects).
module tb_id_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc4, if_inst, wb_data;
  logic        ex_wreg, ex_m2reg, mem_wreg, wb_wreg;
  logic [4:0]  ex_rn, mem_rn, wb_rn;
  logic [31:0] npc, nid_pc, id_ra, id_rb, id_imm;
  logic        ctrl_branch, jmp_stall, id_wpcir;
  logic [4:0]  id_rn;
  logic        id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift;
  logic [3:0]  id_aluc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_stage #(.NOP_INST(NOP), .RF_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .if_pc4(if_pc4), .if_inst(if_inst),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
    .mem_wreg(mem_wreg), .mem_rn(mem_rn),
    .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data),
    .npc(npc), .nid_pc(nid_pc), .ctrl_branch(ctrl_branch), .jmp_stall(jmp_stall),
    .id_wpcir(id_wpcir), .id_ra(id_ra), .id_rb(id_rb), .id_imm(id_imm), .id_rn(id_rn),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_aluimm(id_aluimm), .id_shift(id_shift), .id_aluc(id_aluc)
  );

  typedef struct packed {
    logic [31:0] npc, nid_pc;
    logic        ctrl, jstall, wpcir;
    logic [31:0] ra, rb, imm;
    logic [4:0]  rn;
    logic        wreg, m2reg, wmem, aluimm, shift;
    logic [3:0]  aluc;
  } out_t;

  typedef enum {M_NOP, M_ADD, M_SUB, M_AND, M_OR, M_NOR, M_SLT, M_SLL, M_SRL, M_SRA,
                M_ADDI, M_ANDI, M_ORI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_BAD} mn_t;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc4, m_inst;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic mn_t classify(input logic [31:0] i);
    if (i == NOP) return M_NOP;
    case (i[31:26])
      6'h00: case (i[5:0])
               6'h20: return M_ADD;  6'h22: return M_SUB;  6'h24: return M_AND;
               6'h25: return M_OR;   6'h27: return M_NOR;  6'h2a: return M_SLT;
               6'h00: return M_SLL;  6'h02: return M_SRL;  6'h03: return M_SRA;
               default: return M_BAD;
             endcase
      6'h08: return M_ADDI; 6'h0c: return M_ANDI; 6'h0d: return M_ORI;
      6'h23: return M_LW;   6'h2b: return M_SW;   6'h04: return M_BEQ;
      6'h05: return M_BNE;  6'h02: return M_J;
      default: return M_BAD;
    endcase
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_wreg && wb_rn == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic out_t model_out();
    out_t e;
    mn_t m;
    logic [4:0] rs, rt;
    logic [31:0] sx, tgt;
    logic rtype, uses_rt, lu, bs, taken;
    e = '0;
    m = classify(m_inst);
    rs = m_inst[25:21];
    rt = m_inst[20:16];
    sx = {{16{m_inst[15]}}, m_inst[15:0]};
    rtype = (m_inst[31:26] == 6'h00) && (m != M_NOP);
    uses_rt = rtype || m == M_SW || m == M_BEQ || m == M_BNE;
    e.ra = rd_reg(rs);
    e.rb = rd_reg(rt);
    e.rn = (m == M_NOP) ? 5'd0 : (rtype ? m_inst[15:11] : rt);
    e.imm = (m == M_NOP) ? 32'h0 : sx;
    case (m)
      M_ADD:  begin e.wreg = 1; e.aluc = 0; end
      M_SUB:  begin e.wreg = 1; e.aluc = 1; end
      M_AND:  begin e.wreg = 1; e.aluc = 2; end
      M_OR:   begin e.wreg = 1; e.aluc = 3; end
      M_NOR:  begin e.wreg = 1; e.aluc = 4; end
      M_SLT:  begin e.wreg = 1; e.aluc = 5; end
      M_SLL:  begin e.wreg = 1; e.aluc = 6; e.shift = 1; e.imm = 32'(m_inst[10:6]); end
      M_SRL:  begin e.wreg = 1; e.aluc = 7; e.shift = 1; e.imm = 32'(m_inst[10:6]); end
      M_SRA:  begin e.wreg = 1; e.aluc = 8; e.shift = 1; e.imm = 32'(m_inst[10:6]); end
      M_ADDI: begin e.wreg = 1; e.aluimm = 1; end
      M_ANDI: begin e.wreg = 1; e.aluimm = 1; e.aluc = 2; e.imm = 32'(m_inst[15:0]); end
      M_ORI:  begin e.wreg = 1; e.aluimm = 1; e.aluc = 3; e.imm = 32'(m_inst[15:0]); end
      M_LW:   begin e.wreg = 1; e.m2reg = 1; e.aluimm = 1; end
      M_SW:   begin e.wmem = 1; e.aluimm = 1; end
      default: ;
    endcase
    lu = ex_wreg && ex_m2reg && ex_rn != 0 && (ex_rn == rs || (uses_rt && ex_rn == rt));
    bs = (m == M_BEQ || m == M_BNE) &&
         ((ex_wreg && ex_rn != 0 && (ex_rn == rs || ex_rn == rt)) ||
          (mem_wreg && mem_rn != 0 && (mem_rn == rs || mem_rn == rt)));
    e.wpcir = lu || bs;
    if (e.wpcir) begin e.wreg = 0; e.m2reg = 0; e.wmem = 0; end
    taken = !e.wpcir && ((m == M_BEQ && e.ra == e.rb) || (m == M_BNE && e.ra != e.rb) || m == M_J);
    tgt = (m == M_J) ? {m_pc4[31:26], m_inst[25:0]} : m_pc4 + sx;
    e.ctrl = taken;
    e.jstall = taken;
    e.nid_pc = taken ? tgt : 32'h0;
    e.npc = taken ? tgt : if_pc4;
    return e;
  endfunction

  function automatic out_t get_obs();
    out_t o;
    o.npc = npc; o.nid_pc = nid_pc; o.ctrl = ctrl_branch; o.jstall = jmp_stall;
    o.wpcir = id_wpcir; o.ra = id_ra; o.rb = id_rb; o.imm = id_imm; o.rn = id_rn;
    o.wreg = id_wreg; o.m2reg = id_m2reg; o.wmem = id_wmem; o.aluimm = id_aluimm;
    o.shift = id_shift; o.aluc = id_aluc;
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pc4 = 32'h0;
    m_inst = NOP;
  endtask

  task automatic tick();
    out_t e;
    e = model_out();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (wb_wreg && wb_rn != 0) m_regs[wb_rn] = wb_data;
      if (!e.wpcir) begin
        if (e.ctrl) begin m_pc4 = 32'h0; m_inst = NOP; end
        else begin m_pc4 = if_pc4; m_inst = if_inst; end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    ex_wreg = 0; ex_m2reg = 0; ex_rn = 0; mem_wreg = 0; mem_rn = 0;
    wb_wreg = 0; wb_rn = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    out_t e, o;
    rst = 1;
    idle_inputs();
    if_pc4 = $urandom; if_inst = $urandom;
    model_reset();
    @(negedge clk);
    e = '0; e.npc = if_pc4;
    o = get_obs();
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_state: got %h want %h", o, e); end
    rst = 0;
  endtask

  task automatic test_addi();
    out_t e, o;
    if_inst = enc_i(6'h08, 0, 1, 16'd5); if_pc4 = 32'h1;
    tick();
    if_inst = enc_i(6'h08, 0, 2, 16'hFFFF); if_pc4 = 32'h2;
    @(negedge clk);
    e = model_out(); o = get_obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL addi5_model: got %h want %h", o, e); end
    n_tests++;
    if ({id_imm, id_aluc, id_aluimm, id_rn, id_wreg} !== {32'd5, 4'd0, 1'b1, 5'd1, 1'b1}) begin
      n_fail++; $display("FAIL addi5_fields: got imm=%h aluc=%0d rn=%0d", id_imm, id_aluc, id_rn);
    end
    tick();
    if_inst = NOP;
    @(negedge clk);
    n_tests++;
    if ({id_imm, id_aluc, id_aluimm, id_rn} !== {32'hFFFF_FFFF, 4'd0, 1'b1, 5'd2}) begin
      n_fail++; $display("FAIL addi_neg1_fields: got imm=%h aluc=%0d rn=%0d", id_imm, id_aluc, id_rn);
    end
    tick();
  endtask

  task automatic test_load_use();
    out_t e, o;
    if_inst = enc_r(3, 1, 4, 0, 6'h20);
    tick();
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 3;
    if_inst = enc_i(6'h0d, 0, 11, 16'h1);
    @(negedge clk);
    e = model_out(); o = get_obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL loaduse_stall_model: got %h want %h", o, e); end
    n_tests++;
    if (id_wpcir !== 1'b1 || id_wreg !== 1'b0) begin
      n_fail++; $display("FAIL loaduse_stall: got wpcir=%b wreg=%b want 1 0", id_wpcir, id_wreg);
    end
    tick();
    idle_inputs(); mem_wreg = 1; mem_rn = 3;
    @(negedge clk);
    n_tests++;
    if (id_wpcir !== 1'b0 || id_wreg !== 1'b1 || id_rn !== 5'd4) begin
      n_fail++; $display("FAIL loaduse_release: got wpcir=%b wreg=%b rn=%0d want 0 1 4", id_wpcir, id_wreg, id_rn);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch_jump();
    out_t e, o;
    if_inst = NOP;
    wb_wreg = 1; wb_rn = 5; wb_data = 7; tick();
    wb_rn = 6; tick();
    idle_inputs();
    if_inst = enc_i(6'h04, 5, 6, 16'hFFFD); if_pc4 = 32'h10;
    tick();
    if_inst = $urandom; if_pc4 = 32'h11;
    @(negedge clk);
    e = model_out(); o = get_obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL beq_model: got %h want %h", o, e); end
    n_tests++;
    if ({ctrl_branch, jmp_stall, nid_pc, npc} !== {1'b1, 1'b1, 32'h0D, 32'h0D}) begin
      n_fail++; $display("FAIL beq_taken: got ctrl=%b nid=%h npc=%h want 1 0d 0d", ctrl_branch, nid_pc, npc);
    end
    tick();
    if_inst = enc_i(6'h05, 5, 6, 16'hFFFD); if_pc4 = 32'h12;
    @(negedge clk);
    n_tests++;
    if ({ctrl_branch, id_wreg, id_rn, id_aluc} !== {1'b0, 1'b0, 5'd0, 4'd0}) begin
      n_fail++; $display("FAIL flush_nop: got ctrl=%b wreg=%b rn=%0d want 0 0 0", ctrl_branch, id_wreg, id_rn);
    end
    tick();
    if_inst = {6'h02, 26'h20}; if_pc4 = 32'h30;
    @(negedge clk);
    n_tests++;
    if (ctrl_branch !== 1'b0 || npc !== 32'h30) begin
      n_fail++; $display("FAIL bne_not_taken: got ctrl=%b npc=%h want 0 30", ctrl_branch, npc);
    end
    tick();
    if_inst = $urandom; if_pc4 = 32'h31;
    @(negedge clk);
    n_tests++;
    if (npc !== 32'h20 || jmp_stall !== 1'b1 || nid_pc !== 32'h20) begin
      n_fail++; $display("FAIL jump: got npc=%h jstall=%b want 20 1", npc, jmp_stall);
    end
    tick();
  endtask

  task automatic test_branch_stall();
    out_t e, o;
    if_inst = NOP;
    wb_wreg = 1; wb_rn = 8; wb_data = 32'h55; tick();
    wb_rn = 7; wb_data = 32'h11;
    if_inst = enc_i(6'h04, 7, 8, 16'd2); if_pc4 = 32'h40;
    tick();
    idle_inputs(); ex_wreg = 1; ex_rn = 7;
    if_inst = enc_i(6'h08, 0, 13, 16'd9); if_pc4 = 32'h41;
    @(negedge clk);
    n_tests++;
    if (id_wpcir !== 1'b1 || ctrl_branch !== 1'b0) begin
      n_fail++; $display("FAIL brstall_ex: got wpcir=%b ctrl=%b want 1 0", id_wpcir, ctrl_branch);
    end
    tick();
    idle_inputs(); mem_wreg = 1; mem_rn = 7;
    @(negedge clk);
    n_tests++;
    if (id_wpcir !== 1'b1 || ctrl_branch !== 1'b0) begin
      n_fail++; $display("FAIL brstall_mem: got wpcir=%b ctrl=%b want 1 0", id_wpcir, ctrl_branch);
    end
    tick();
    idle_inputs(); wb_wreg = 1; wb_rn = 7; wb_data = 32'h55;
    @(negedge clk);
    e = model_out(); o = get_obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL brstall_resolve_model: got %h want %h", o, e); end
    n_tests++;
    if (id_wpcir !== 1'b0 || ctrl_branch !== 1'b1 || npc !== 32'h42) begin
      n_fail++; $display("FAIL brstall_resolve: got wpcir=%b ctrl=%b npc=%h want 0 1 42", id_wpcir, ctrl_branch, npc);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_bypass();
    if_inst = enc_r(9, 0, 10, 0, 6'h20);
    tick();
    wb_wreg = 1; wb_rn = 9; wb_data = 32'hDEAD;
    if_inst = enc_r(0, 9, 12, 0, 6'h20);
    @(negedge clk);
    n_tests++;
    if (id_ra !== 32'hDEAD) begin n_fail++; $display("FAIL bypass: got ra=%h want dead", id_ra); end
    tick();
    wb_rn = 0; wb_data = 32'h1234;
    @(negedge clk);
    n_tests++;
    if (id_ra !== 32'h0 || id_rb !== 32'hDEAD) begin
      n_fail++; $display("FAIL reg0_and_stored: got ra=%h rb=%h want 0 dead", id_ra, id_rb);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_stall();
    out_t e, o;
    if_inst = enc_r(3, 1, 4, 0, 6'h20);
    tick();
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 3;
    @(negedge clk);
    #1 rst = 1;
    model_reset();
    #1;
    e = '0; e.npc = if_pc4; o = get_obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_mid_stall: got %h want %h", o, e); end
    #1 rst = 0;
    idle_inputs();
    if_inst = enc_i(6'h0c, 2, 14, 16'h8001); if_pc4 = 32'h77;
    tick();
    @(negedge clk);
    n_tests++;
    if ({id_imm, id_aluc, id_rn, id_wreg} !== {32'h0000_8001, 4'd2, 5'd14, 1'b1}) begin
      n_fail++; $display("FAIL after_reset_decode: got imm=%h aluc=%0d rn=%0d", id_imm, id_aluc, id_rn);
    end
    tick();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] functs [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02, 6'h03};
    logic [5:0] iops [7] = '{6'h08, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h05};
    logic [4:0] rs, rt, rd;
    logic [31:0] r;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 6))
      0, 1: r = enc_r(rs, rt, rd, 5'($urandom), functs[$urandom_range(0, 8)]);
      2, 3, 4: r = enc_i(iops[$urandom_range(0, 6)], rs, rt, 16'($urandom));
      5: r = {6'h02, 26'($urandom)};
      default: r = $urandom;
    endcase
    return r;
  endfunction

  task automatic test_random();
    out_t e, o;
    for (int k = 0; k < 400; k++) begin
      if_inst = rand_inst(); if_pc4 = $urandom;
      ex_wreg = 1'($urandom); ex_m2reg = 1'($urandom); ex_rn = 5'($urandom_range(0, 7));
      mem_wreg = 1'($urandom); mem_rn = 5'($urandom_range(0, 7));
      wb_wreg = 1'($urandom); wb_rn = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: wb_data = 32'h0;
        1: wb_data = 32'h7;
        default: wb_data = $urandom;
      endcase
      @(negedge clk);
      e = model_out(); o = get_obs(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL random_%0d: got %h want %h", k, o, e); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    if_pc4 = 0; if_inst = NOP;
    test_reset();
    tick();
    test_addi();
    test_load_use();
    test_branch_jump();
    test_branch_stall();
    test_bypass();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
